// File: rtl/ifid_skid_stage.sv
// ---------------------------------------------------------------------------
// ifid_skid_stage
//   IF/ID pipeline stage with a valid/ready handshake. It holds up to two
//   {pc, inst} entries: a head register that drives decode directly and a
//   skid register. The skid register absorbs the one extra entry that can
//   arrive after decode stops accepting. in_ready_o and out_valid_o are
//   registered flags. They never depend combinationally on in_valid_i or on
//   out_ready_i.
//   Two saturating counters record stall cycles and flush cycles for
//   profiling.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   flush_i      drop every held entry (taken branch/jump)
//   in_valid_i   fetch presents {pc_i, inst_i}
//   in_ready_o   stage can accept an entry (low only when both entries are used)
//   pc_i         fetched PC
//   inst_i       fetched instruction
//   out_valid_o  head entry is valid
//   out_ready_i  decode consumes the head entry
//   pc_o         head PC, 0 when no entry is valid
//   inst_o       head instruction, NOP_INST when no entry is valid
//   stall_cnt_o  cycles with out_valid_o=1 and out_ready_i=0 (saturating)
//   flush_cnt_o  cycles with flush_i=1 (saturating)
// ---------------------------------------------------------------------------
module ifid_skid_stage #(
    parameter int                 PC_W     = 32,
    parameter int                 INST_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [PC_W-1:0]     head_pc_q, head_pc_d;
    logic [INST_W-1:0]   head_inst_q, head_inst_d;
    logic [PC_W-1:0]     skid_pc_q, skid_pc_d;
    logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic push;
    logic pop;

    // Handshakes are qualified by the registered flags. No input reaches
    // an output through combinational logic.
    assign push = in_valid_i & in_ready_q;
    assign pop  = out_valid_q & out_ready_i;

    always_comb begin
        state_d     = state_q;
        head_pc_d   = head_pc_q;
        head_inst_d = head_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;

        if (flush_i) begin
            // Flush wins. A push in the same cycle is dropped. A pop in the
            // same cycle has already been taken by decode.
            state_d     = S_EMPTY;
            head_pc_d   = '0;
            head_inst_d = NOP_INST;
            skid_pc_d   = '0;
            skid_inst_d = NOP_INST;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_d     = S_ONE;
                        head_pc_d   = pc_i;
                        head_inst_d = inst_i;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head_pc_d   = pc_i;
                        head_inst_d = inst_i;
                    end else if (push) begin
                        state_d     = S_FULL;
                        skid_pc_d   = pc_i;
                        skid_inst_d = inst_i;
                    end else if (pop) begin
                        // Clearing the head on empty keeps pc_o/inst_o at the
                        // bubble values straight from the register.
                        state_d     = S_EMPTY;
                        head_pc_d   = '0;
                        head_inst_d = NOP_INST;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        state_d     = S_ONE;
                        head_pc_d   = skid_pc_q;
                        head_inst_d = skid_inst_q;
                        skid_pc_d   = '0;
                        skid_inst_d = NOP_INST;
                    end
                end
                default: begin
                    state_d     = S_EMPTY;
                    head_pc_d   = '0;
                    head_inst_d = NOP_INST;
                    skid_pc_d   = '0;
                    skid_inst_d = NOP_INST;
                end
            endcase
        end

        in_ready_d  = (state_d != S_FULL);
        out_valid_d = (state_d != S_EMPTY);
    end

    // The stall and flush counters are independent. Both can count in the
    // same cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid_q && !out_ready_i && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_i && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_pc_q   <= '0;
            head_inst_q <= NOP_INST;
            skid_pc_q   <= '0;
            skid_inst_q <= NOP_INST;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_pc_q   <= head_pc_d;
            head_inst_q <= head_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign pc_o        = head_pc_q;
    assign inst_o      = head_inst_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_ifid_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_ifid_skid_stage
//   Scoreboard bench for ifid_skid_stage. Each accepted entry is queued when
//   it is driven. On every cycle the head of the queue is compared with
//   pc_o/inst_o. The queue is popped when decode consumes the entry and is
//   emptied on flush. The handshake flags and the saturating counters are
//   checked against the queue occupancy and against model counters.
// ---------------------------------------------------------------------------
module tb_ifid_skid_stage;

    localparam int          PC_W   = 32;
    localparam int          INST_W = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_i;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [PC_W-1:0]   pc_i;
    logic [INST_W-1:0] inst_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [PC_W-1:0]   pc_o;
    logic [INST_W-1:0] inst_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    ifid_skid_stage #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .pc_i        (pc_i),
        .inst_i      (inst_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .pc_o        (pc_o),
        .inst_o      (inst_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t sb[$];
    int     checks   = 0;
    int     failures = 0;
    int     m_stall  = 0;
    int     m_flush  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle. The call starts just after a rising edge and returns
    // just after the next one. Outputs are checked on the falling edge.
    task automatic step(input bit v, input bit r, input bit f,
                        input logic [31:0] pc, input logic [31:0] inst);
        entry_t e;
        bit     push;
        bit     pop;
        in_valid_i  = v;
        out_ready_i = r;
        flush_i     = f;
        pc_i        = pc;
        inst_i      = inst;
        @(negedge clk);
        chk("in_ready", in_ready_o, sb.size() != 2);
        chk("out_valid", out_valid_o, sb.size() != 0);
        if (sb.size() != 0) begin
            chk("head_pc", pc_o, sb[0].pc);
            chk("head_inst", inst_o, sb[0].inst);
        end else begin
            chk("bubble_pc", pc_o, 0);
            chk("bubble_inst", inst_o, NOP);
        end
        chk("stall_cnt", stall_cnt_o, m_stall);
        chk("flush_cnt", flush_cnt_o, m_flush);
        $display("cyc v=%0b r=%0b f=%0b pc_i=%0h | ov=%0b pc_o=%0h ir=%0b occ=%0d",
                 v, r, f, pc, out_valid_o, pc_o, in_ready_o, sb.size());

        push = v && (sb.size() < 2);
        pop  = r && (sb.size() > 0);
        if (sb.size() > 0 && !r && m_stall < CMAX) m_stall++;
        if (f && m_flush < CMAX) m_flush++;
        if (f) begin
            sb.delete();
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) begin
                e.pc   = pc;
                e.inst = inst;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] next_pc;

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        pc_i        = '0;
        inst_i      = '0;
        #1;
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_stall", stall_cnt_o, 0);
        chk("rst_flush", flush_cnt_o, 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // 1. Streaming
        step(1, 1, 0, 32'h00, 32'hA000_0000);
        chk("stream_pc0", pc_o, 32'h00);
        step(1, 1, 0, 32'h04, 32'hA000_0004);
        chk("stream_pc1", pc_o, 32'h04);
        chk("stream_ready", in_ready_o, 1);
        step(1, 1, 0, 32'h08, 32'hA000_0008);
        chk("stream_pc2", pc_o, 32'h08);
        chk("stream_stall", stall_cnt_o, 0);
        step(0, 1, 0, 32'h0, 32'h0);

        // 2. Back-pressure
        step(1, 0, 0, 32'h10, 32'hB000_0010);
        step(1, 0, 0, 32'h14, 32'hB000_0014);
        chk("bp_full_ready", in_ready_o, 0);
        chk("bp_head", pc_o, 32'h10);
        step(1, 0, 0, 32'h99, 32'hDEAD_BEEF);   // not accepted while full
        step(0, 0, 0, 32'h0, 32'h0);
        chk("bp_stall", stall_cnt_o, 3);
        step(0, 1, 0, 32'h0, 32'h0);
        chk("bp_second", pc_o, 32'h14);
        step(0, 1, 0, 32'h0, 32'h0);
        chk("bp_drained", out_valid_o, 0);

        // 3. Flush while full with a simultaneous push
        step(1, 0, 0, 32'h30, 32'hC000_0030);
        step(1, 0, 0, 32'h34, 32'hC000_0034);
        step(1, 0, 1, 32'h18, 32'hC000_0018);
        chk("fl_valid", out_valid_o, 0);
        chk("fl_pc", pc_o, 0);
        chk("fl_inst", inst_o, NOP);
        chk("fl_ready", in_ready_o, 1);
        chk("fl_cnt", flush_cnt_o, 1);
        step(0, 1, 0, 32'h0, 32'h0);

        // 4. Asynchronous reset in the middle of a cycle while full
        step(1, 0, 0, 32'h40, 32'hD000_0040);
        step(1, 0, 0, 32'h44, 32'hD000_0044);
        #1 rst_i = 1'b1;
        #1;
        chk("arst_valid", out_valid_o, 0);
        chk("arst_ready", in_ready_o, 1);
        chk("arst_pc", pc_o, 0);
        chk("arst_inst", inst_o, NOP);
        chk("arst_stall", stall_cnt_o, 0);
        chk("arst_flush", flush_cnt_o, 0);
        sb.delete();
        m_stall = 0;
        m_flush = 0;
        #1 rst_i = 1'b0;
        step(1, 1, 0, 32'h20, 32'hE000_0020);
        chk("arst_push_valid", out_valid_o, 1);
        chk("arst_push_pc", pc_o, 32'h20);

        // 5. Stall counter saturation
        for (int i = 0; i < 20; i++) step(0, 0, 0, 32'h0, 32'h0);
        chk("sat_stall", stall_cnt_o, 15);
        step(0, 1, 0, 32'h0, 32'h0);

        // 6. Random traffic
        next_pc = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            bit v, r, f;
            v = ($urandom % 4) != 0;
            r = ($urandom % 3) != 0;
            f = ($urandom % 32) == 0;
            step(v, r, f, next_pc, $urandom);
            next_pc += 4;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
